// File: rtl/xbar_slave_arbiter_pkg.sv
// Shared cross-bar definitions: bus widths, command encodings and the
// slave-port arbiter state encoding.
package interface_connection;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/xbar_slave_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward with wrap-around.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx_c,
    output logic             grant_valid_c
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        idx           = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!grant_valid_c && req[idx]) begin
                grant_idx_c   = idx;
                grant_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port arbiter: locks one master onto the slave until it acks,
// then returns ack and next-cycle read data to that master only.
module xbar_slave_arbiter
    import interface_connection::*;
#(
    parameter int unsigned N_MASTERS  = 4,
    parameter int unsigned ADDR_WIDTH = interface_connection::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = interface_connection::DATA_WIDTH,
    parameter int unsigned IDX_W      = $clog2(N_MASTERS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_MASTERS-1:0]                 m_req,
    input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTERS-1:0]                 m_cmd,
    input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata,
    output logic [N_MASTERS-1:0]                 m_ack,
    output logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata,
    output logic [N_MASTERS-1:0]                 m_rvalid,
    output logic                                 s_req,
    output logic [ADDR_WIDTH-1:0]                s_addr,
    output logic                                 s_cmd,
    output logic [DATA_WIDTH-1:0]                s_wdata,
    input  logic                                 s_ack,
    input  logic [DATA_WIDTH-1:0]                s_rdata,
    output logic [IDX_W-1:0]                     grant_id
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] grant_nxt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .N_REQ (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req           (m_req),
        .ptr           (ptr),
        .grant_idx_c   (arb_idx),
        .grant_valid_c (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant_id <= grant_nxt;
        end
    end

    // Slave-side routing is a live mux of the locked master; returns go to it alone.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant_id;
        s_req     = 1'b0;
        s_addr    = '0;
        s_cmd     = 1'b0;
        s_wdata   = '0;
        m_ack     = '0;
        m_rdata   = '0;
        m_rvalid  = '0;
        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_nxt = arb_idx;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                s_req           = 1'b1;
                s_addr          = m_addr[grant_id];
                s_cmd           = m_cmd[grant_id];
                s_wdata         = m_wdata[grant_id];
                m_ack[grant_id] = s_ack;
                if (s_ack) begin
                    ptr_nxt   = grant_id + IDX_W'(1);
                    state_nxt = (m_cmd[grant_id] == CMD_READ) ? S_RESP : S_IDLE;
                end
            end
            S_RESP: begin
                m_rdata[grant_id]  = s_rdata;
                m_rvalid[grant_id] = 1'b1;
                state_nxt          = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Protocol checks: stray slave acks and masters abandoning a locked request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(s_ack && state != S_REQ))
                else $error("s_ack outside REQ state");
            assert (!(state == S_REQ && !m_req[grant_id]))
                else $error("granted master dropped m_req before ack");
        end
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter with hand-computed expectations.
module tb_xbar_slave_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NM-1:0]          m_req;
    logic [NM-1:0][AW-1:0]  m_addr;
    logic [NM-1:0]          m_cmd;
    logic [NM-1:0][DW-1:0]  m_wdata;
    logic [NM-1:0]          m_ack;
    logic [NM-1:0][DW-1:0]  m_rdata;
    logic [NM-1:0]          m_rvalid;
    logic                   s_req;
    logic [AW-1:0]          s_addr;
    logic                   s_cmd;
    logic [DW-1:0]          s_wdata;
    logic                   s_ack;
    logic [DW-1:0]          s_rdata;
    logic [1:0]             grant_id;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    xbar_slave_arbiter #(.N_MASTERS(NM)) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_cmd    (m_cmd),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .m_rvalid (m_rvalid),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_cmd    (s_cmd),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata),
        .grant_id (grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0;
        s_ack = 1'b0; s_rdata = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (s_req !== 1'b0) $display("FAIL reset_s_req got %0b want 0", s_req); else passed++;
        total++; if (grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_id); else passed++;
        total++; if ({m_ack, m_rvalid} !== 8'h00) $display("FAIL reset_acks got %h want 00", {m_ack, m_rvalid}); else passed++;
        total++; if ({s_addr, s_wdata, m_rdata} !== '0) $display("FAIL reset_data got nonzero want 0"); else passed++;
    endtask

    task automatic test_single_write();
        int sreq_cycles = 0;
        apply_reset();
        m_req = 4'b0100; m_cmd = 4'b0100;
        m_addr[2] = 32'h0000_0010; m_wdata[2] = 32'hDEAD_BEEF;
        #1;
        total++; if (s_req !== 1'b0) $display("FAIL wr_latency got s_req=%0b want 0", s_req); else passed++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) s_ack = 1'b1;
            #1;
            if (s_req === 1'b1) sreq_cycles++;
            total++; if (grant_id !== 2'd2) $display("FAIL wr_grant got %0d want 2", grant_id); else passed++;
            total++; if (s_addr !== 32'h10 || s_wdata !== 32'hDEAD_BEEF || s_cmd !== 1'b1)
                $display("FAIL wr_route got %h/%h/%0b want 10/deadbeef/1", s_addr, s_wdata, s_cmd); else passed++;
            total++; if (m_ack !== ((c == 2) ? 4'b0100 : 4'b0000))
                $display("FAIL wr_ack got %b want %b", m_ack, (c == 2) ? 4'b0100 : 4'b0000); else passed++;
        end
        tick();
        s_ack = 1'b0; m_req = '0;
        #1;
        if (s_req === 1'b1) sreq_cycles++;
        total++; if (sreq_cycles != 3) $display("FAIL wr_sreq_len got %0d want 3", sreq_cycles); else passed++;
        total++; if (m_ack !== 4'b0000) $display("FAIL wr_ack_after got %b want 0000", m_ack); else passed++;
        total++; if (dut.ptr !== 2'd3) $display("FAIL wr_ptr got %0d want 3", dut.ptr); else passed++;
    endtask

    task automatic test_contention();
        apply_reset();
        m_req = 4'b1111; m_cmd = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            m_addr[i]  = 32'h100 + 32'(i);
            m_wdata[i] = 32'hA000 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            logic [1:0] exp_g;
            exp_g = 2'(k % 4);
            tick();
            s_ack = 1'b1;
            #1;
            total++; if (grant_id !== exp_g) $display("FAIL cont_order got %0d want %0d", grant_id, exp_g); else passed++;
            total++; if (s_addr !== 32'h100 + 32'(exp_g) || s_wdata !== 32'hA000 + 32'(exp_g))
                $display("FAIL cont_route got %h/%h want master %0d", s_addr, s_wdata, exp_g); else passed++;
            total++; if (m_ack !== (4'b0001 << exp_g)) $display("FAIL cont_ack got %b want %b", m_ack, 4'b0001 << exp_g); else passed++;
            tick();
            s_ack = 1'b0;
            #1;
            total++; if (s_req !== 1'b0) $display("FAIL cont_idle got s_req=%0b want 0", s_req); else passed++;
        end
        m_req = '0;
        tick();
    endtask

    task automatic test_read_routing();
        apply_reset();
        m_req = 4'b0010; m_cmd = 4'b0000; m_addr[1] = 32'h0000_0044;
        tick();
        s_ack = 1'b1;
        #1;
        total++; if (s_cmd !== 1'b0 || s_addr !== 32'h44) $display("FAIL rd_route got %0b/%h want 0/44", s_cmd, s_addr); else passed++;
        total++; if (m_ack !== 4'b0010 || m_rvalid !== 4'b0000) $display("FAIL rd_ack got %b/%b want 0010/0000", m_ack, m_rvalid); else passed++;
        tick();
        s_ack = 1'b0; s_rdata = 32'h1234_5678; m_req = '0;
        #1;
        total++; if (m_rvalid !== 4'b0010) $display("FAIL rd_rvalid got %b want 0010", m_rvalid); else passed++;
        total++; if (m_rdata[1] !== 32'h1234_5678) $display("FAIL rd_rdata got %h want 12345678", m_rdata[1]); else passed++;
        total++; if ({m_rdata[3], m_rdata[2], m_rdata[0]} !== 96'h0) $display("FAIL rd_others got nonzero want 0"); else passed++;
        total++; if (s_req !== 1'b0 || m_ack !== 4'b0000) $display("FAIL rd_resp_sreq got %0b/%b want 0/0000", s_req, m_ack); else passed++;
        tick();
        #1;
        total++; if (m_rvalid !== 4'b0000 || m_rdata !== '0) $display("FAIL rd_one_cycle got rvalid=%b want 0000", m_rvalid); else passed++;
    endtask

    task automatic test_stall();
        int bad = 0;
        apply_reset();
        m_req = 4'b0001; m_cmd = 4'b1001;
        tick();
        m_req = 4'b1001;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (grant_id !== 2'd0 || s_req !== 1'b1 || m_ack !== 4'b0000) bad++;
            tick();
        end
        total++; if (bad != 0) $display("FAIL stall_lock got %0d bad cycles want 0", bad); else passed++;
        s_ack = 1'b1;
        #1;
        total++; if (m_ack !== 4'b0001) $display("FAIL stall_ack got %b want 0001", m_ack); else passed++;
        tick();
        s_ack = 1'b0; m_req = 4'b1000;
        tick();
        total++; if (grant_id !== 2'd3 || s_req !== 1'b1) $display("FAIL stall_next got %0d/%0b want 3/1", grant_id, s_req); else passed++;
        s_ack = 1'b1;
        #1;
        total++; if (m_ack !== 4'b1000) $display("FAIL stall_ack3 got %b want 1000", m_ack); else passed++;
        tick();
        s_ack = 1'b0; m_req = '0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        m_req = 4'b0100; m_cmd = 4'b0000;
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; s_rdata = 32'hAAAA_5555; m_req = '0; rst = 1'b1;
        #1;
        total++; if (m_rvalid !== 4'b0100) $display("FAIL rst_pre got %b want 0100", m_rvalid); else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++; if (m_rvalid !== 4'b0000 || m_rdata !== '0) $display("FAIL rst_rvalid got %b want 0000", m_rvalid); else passed++;
        total++; if (s_req !== 1'b0 || m_ack !== 4'b0000 || grant_id !== 2'd0)
            $display("FAIL rst_outs got %0b/%b/%0d want 0/0000/0", s_req, m_ack, grant_id); else passed++;
        total++; if (dut.ptr !== 2'd0) $display("FAIL rst_ptr got %0d want 0", dut.ptr); else passed++;
        m_req = 4'b0101; m_cmd = 4'b0101;
        tick();
        total++; if (grant_id !== 2'd0 || s_req !== 1'b1) $display("FAIL rst_first got %0d/%0b want 0/1", grant_id, s_req); else passed++;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m_req = '0;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        m_req = 4'b1000; m_cmd = 4'b1001;
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m_req = 4'b1001;
        #1;
        total++; if (dut.ptr !== 2'd0) $display("FAIL wrap_ptr got %0d want 0", dut.ptr); else passed++;
        tick();
        total++; if (grant_id !== 2'd0) $display("FAIL wrap_first got %0d want 0", grant_id); else passed++;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        tick();
        total++; if (grant_id !== 2'd3) $display("FAIL wrap_second got %0d want 3", grant_id); else passed++;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m_req = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1; m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0;
        s_ack = 1'b0; s_rdata = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_read_routing();
        test_stall();
        test_reset_mid_read();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
